// File: rtl/sprite_mover.sv
// Keyboard-driven sprite engine: erase-then-draw pixel stream for the VGA plotter.
// First pixel two cycles after an accepted key; keys arriving while busy are dropped.
module sprite_mover #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int SPRITE_W        = 4,
    parameter int SPRITE_H        = 4,
    parameter int STEP            = 1,
    parameter int START_X         = 10,
    parameter int START_Y         = 10,
    parameter logic [2:0] FG_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [7:0] iKey,
    input  logic       iKeyValid,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] oPosX,
    output logic [6:0] oPosY
);
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_ERASE = 3'd3;
    localparam logic [2:0] S_DRAW  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    localparam logic signed [9:0] STEP_S = 10'(STEP);
    localparam logic signed [9:0] X_MAX  = 10'(X_SCREEN_PIXELS - SPRITE_W);
    localparam logic signed [9:0] Y_MAX  = 10'(Y_SCREEN_PIXELS - SPRITE_H);
    localparam logic [7:0] W_LAST  = 8'(SPRITE_W - 1);
    localparam logic [6:0] H_LAST  = 7'(SPRITE_H - 1);
    localparam logic [7:0] START_X8 = 8'(START_X);
    localparam logic [6:0] START_Y7 = 7'(START_Y);

    logic [2:0] state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [7:0] pos_x_q, pos_x_d, new_x_q, new_x_d;
    logic [6:0] pos_y_q, pos_y_d, new_y_q, new_y_d;
    logic [7:0] off_x_q, off_x_d;
    logic [6:0] off_y_q, off_y_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, done_q, done_d, busy_q, busy_d;

    logic signed [9:0] cand_x, cand_y;
    logic [7:0] clamp_x;
    logic [6:0] clamp_y;
    logic       last_pix;

    // Candidate is widened so that the signed step never overflows before clamping.
    always_comb begin
        cand_x = signed'({2'b00, pos_x_q});
        cand_y = signed'({3'b000, pos_y_q});
        case (dir_q)
            D_UP:    cand_y = cand_y - STEP_S;
            D_DOWN:  cand_y = cand_y + STEP_S;
            D_LEFT:  cand_x = cand_x - STEP_S;
            default: cand_x = cand_x + STEP_S;
        endcase
        if (cand_x < 10'sd0)      clamp_x = 8'd0;
        else if (cand_x > X_MAX)  clamp_x = X_MAX[7:0];
        else                      clamp_x = cand_x[7:0];
        if (cand_y < 10'sd0)      clamp_y = 7'd0;
        else if (cand_y > Y_MAX)  clamp_y = Y_MAX[6:0];
        else                      clamp_y = cand_y[6:0];
    end

    assign last_pix = (off_x_q == W_LAST) && (off_y_q == H_LAST);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        new_x_d  = new_x_q;
        new_y_d  = new_y_q;
        off_x_d  = off_x_q;
        off_y_d  = off_y_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_INIT, S_ERASE, S_DRAW: begin
                x_d      = pos_x_q + off_x_q;
                y_d      = pos_y_q + off_y_q;
                colour_d = (state_q == S_ERASE) ? BG_COLOUR : FG_COLOUR;
                plot_d   = 1'b1;
                if (off_x_q == W_LAST) begin
                    off_x_d = 8'd0;
                    off_y_d = (off_y_q == H_LAST) ? 7'd0 : off_y_q + 7'd1;
                end else begin
                    off_x_d = off_x_q + 8'd1;
                end
                if (last_pix) begin
                    if (state_q == S_ERASE) begin
                        state_d = S_DRAW;
                        pos_x_d = new_x_q;
                        pos_y_d = new_y_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_IDLE: begin
                if (iKeyValid) begin
                    case (iKey)
                        8'd29: begin dir_d = D_UP;    state_d = S_CALC; end
                        8'd27: begin dir_d = D_DOWN;  state_d = S_CALC; end
                        8'd28: begin dir_d = D_LEFT;  state_d = S_CALC; end
                        8'd35: begin dir_d = D_RIGHT; state_d = S_CALC; end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                new_x_d = clamp_x;
                new_y_d = clamp_y;
                // Already at the edge: nothing to redraw, return quietly.
                if ((clamp_x == pos_x_q) && (clamp_y == pos_y_q)) state_d = S_IDLE;
                else                                               state_d = S_ERASE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase

        busy_d = (state_q != S_IDLE) || (state_d != S_IDLE);
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q  <= S_INIT;
            dir_q    <= D_UP;
            pos_x_q  <= START_X8;
            pos_y_q  <= START_Y7;
            new_x_q  <= START_X8;
            new_y_q  <= START_Y7;
            off_x_q  <= 8'd0;
            off_y_q  <= 7'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            new_x_q  <= new_x_d;
            new_y_q  <= new_y_d;
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oDone   = done_q;
    assign oBusy   = busy_q;
    assign oPosX   = pos_x_q;
    assign oPosY   = pos_y_q;
endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: default build, left-edge build and step-2 right-edge build.
module tb_sprite_mover;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] key;
    logic       kvld;
    logic [1:0] sel;
    logic       kv0, kv1, kv2;

    logic [7:0] ox[3];
    logic [6:0] oy[3];
    logic [2:0] oc[3];
    logic       op[3], od[3], ob[3];
    logic [7:0] opx[3];
    logic [6:0] opy[3];

    assign kv0 = kvld && (sel == 2'd0);
    assign kv1 = kvld && (sel == 2'd1);
    assign kv2 = kvld && (sel == 2'd2);

    sprite_mover u0 (
        .iClock(clk), .iReset(rst), .iKey(key), .iKeyValid(kv0),
        .oX(ox[0]), .oY(oy[0]), .oColour(oc[0]), .oPlot(op[0]), .oDone(od[0]),
        .oBusy(ob[0]), .oPosX(opx[0]), .oPosY(opy[0]));

    sprite_mover #(.START_X(0)) u1 (
        .iClock(clk), .iReset(rst), .iKey(key), .iKeyValid(kv1),
        .oX(ox[1]), .oY(oy[1]), .oColour(oc[1]), .oPlot(op[1]), .oDone(od[1]),
        .oBusy(ob[1]), .oPosX(opx[1]), .oPosY(opy[1]));

    sprite_mover #(.STEP(2), .START_X(155)) u2 (
        .iClock(clk), .iReset(rst), .iKey(key), .iKeyValid(kv2),
        .oX(ox[2]), .oY(oy[2]), .oColour(oc[2]), .oPlot(op[2]), .oDone(od[2]),
        .oBusy(ob[2]), .oPosX(opx[2]), .oPosY(opy[2]));

    int checks = 0;
    int failures = 0;
    int pxs[64];
    int pys[64];
    int pcs[64];

    typedef struct {
        logic [7:0] k;
        int         ex;
        int         ey;
        int         npix;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge clk);
        key  = k;
        kvld = 1'b1;
    endtask

    // Samples the selected DUT on falling edges until oBusy drops; c counts cycles after the strobe edge.
    task automatic capture(input int inj, output int npix, output int ndone, output int nbusy,
                           output int first_i, output int last_i, output int done_i, output int end_i);
        npix = 0; ndone = 0; nbusy = 0;
        first_i = -1; last_i = -1; done_i = -1; end_i = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            kvld = 1'b0;
            if (c == inj) begin
                key  = 8'd29;
                kvld = 1'b1;
            end
            if (op[sel]) begin
                if (npix < 64) begin
                    pxs[npix] = int'(ox[sel]);
                    pys[npix] = int'(oy[sel]);
                    pcs[npix] = int'(oc[sel]);
                end
                if (npix == 0) first_i = c;
                last_i = c;
                npix++;
            end
            if (od[sel]) begin
                ndone++;
                done_i = c;
            end
            if (ob[sel]) nbusy++;
            else begin
                end_i = c;
                break;
            end
        end
        check("capture_bound", (end_i >= 0) ? 1 : 0, 1);
    endtask

    task automatic verify_frame(input string tag, input int npix, input int erase,
                                input int bx0, input int by0, input int bx1, input int by1);
        int n;
        n = (npix < 64) ? npix : 64;
        for (int i = 0; i < n; i++) begin
            int j, ex, ey, ec;
            j = i % 16;
            if (erase != 0 && i < 16) begin
                ex = bx0 + j % 4; ey = by0 + j / 4; ec = 0;
            end else begin
                ex = bx1 + j % 4; ey = by1 + j / 4; ec = 4;
            end
            check($sformatf("%s_px%0d", tag, i), (pxs[i] << 16) | (pys[i] << 8) | pcs[i],
                  (ex << 16) | (ey << 8) | ec);
        end
    endtask

    task automatic check_init(input string tag);
        int np, nd, nb, fi, li, di, ei;
        capture(-1, np, nd, nb, fi, li, di, ei);
        check({tag, "_npix"}, np, 16);
        check({tag, "_first"}, fi, 0);
        check({tag, "_ndone"}, nd, 1);
        check({tag, "_done_after_last"}, di, li + 1);
        check({tag, "_busy_fall"}, ei, di + 1);
        verify_frame(tag, np, 0, 0, 0, 10, 10);
        check({tag, "_posx"}, int'(opx[0]), 10);
        check({tag, "_posy"}, int'(opy[0]), 10);
    endtask

    vec_t vecs[5];

    initial begin
        int np, nd, nb, fi, li, di, ei;
        int cx, cy;

        vecs[0] = '{k: 8'd35, ex: 11, ey: 10, npix: 32};
        vecs[1] = '{k: 8'h55, ex: 11, ey: 10, npix: 0};
        vecs[2] = '{k: 8'd27, ex: 11, ey: 11, npix: 32};
        vecs[3] = '{k: 8'd28, ex: 10, ey: 11, npix: 32};
        vecs[4] = '{k: 8'd29, ex: 10, ey: 10, npix: 32};

        rst = 1'b1; kvld = 1'b0; key = 8'd0; sel = 2'd0;
        #12;
        check("rst_x", int'(ox[0]), 0);
        check("rst_colour", int'(oc[0]), 0);
        check("rst_plot", int'(op[0]), 0);
        check("rst_done", int'(od[0]), 0);
        check("rst_busy", int'(ob[0]), 1);
        check("rst_posx", int'(opx[0]), 10);
        check("rst_posy", int'(opy[0]), 10);

        @(negedge clk);
        rst = 1'b0;
        check_init("init");

        cx = 10; cy = 10;
        for (int v = 0; v < 5; v++) begin
            press(vecs[v].k);
            capture(-1, np, nd, nb, fi, li, di, ei);
            check($sformatf("vec%0d_npix", v), np, vecs[v].npix);
            check($sformatf("vec%0d_ndone", v), nd, (vecs[v].npix > 0) ? 1 : 0);
            check($sformatf("vec%0d_nbusy", v), nb, (vecs[v].npix > 0) ? 35 : 0);
            if (vecs[v].npix > 0) begin
                check($sformatf("vec%0d_first", v), fi, 2);
                check($sformatf("vec%0d_done_after_last", v), di, li + 1);
                check($sformatf("vec%0d_busy_fall", v), ei, di + 1);
                verify_frame($sformatf("vec%0d", v), np, 1, cx, cy, vecs[v].ex, vecs[v].ey);
            end
            check($sformatf("vec%0d_posx", v), int'(opx[0]), vecs[v].ex);
            check($sformatf("vec%0d_posy", v), int'(opy[0]), vecs[v].ey);
            cx = vecs[v].ex; cy = vecs[v].ey;
        end

        // Up key repeated while the erase burst is running must be dropped.
        press(8'd29);
        capture(4, np, nd, nb, fi, li, di, ei);
        check("held_npix", np, 32);
        check("held_ndone", nd, 1);
        verify_frame("held", np, 1, 10, 10, 10, 9);
        check("held_posy", int'(opy[0]), 9);
        nb = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            nb += int'(op[0]) + int'(ob[0]);
        end
        check("held_quiet_after", nb, 0);

        // Reset on the 5th erase pixel of a right move from (10,9).
        press(8'd35);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            kvld = 1'b0;
        end
        check("abort_plot", int'(op[0]), 1);
        check("abort_pix", (int'(ox[0]) << 16) | (int'(oy[0]) << 8) | int'(oc[0]), (10 << 16) | (10 << 8));
        rst = 1'b1;
        #1;
        check("abort_x", int'(ox[0]), 0);
        check("abort_y", int'(oy[0]), 0);
        check("abort_plot_low", int'(op[0]), 0);
        check("abort_busy", int'(ob[0]), 1);
        check("abort_posx", int'(opx[0]), 10);
        check("abort_posy", int'(opy[0]), 10);
        @(negedge clk);
        rst = 1'b0;
        check_init("reinit");

        // Left edge build: left key is clamped, nothing plotted.
        sel = 2'd1;
        press(8'd28);
        capture(-1, np, nd, nb, fi, li, di, ei);
        check("ledge_npix", np, 0);
        check("ledge_ndone", nd, 0);
        check("ledge_nbusy", nb, 2);
        check("ledge_posx", int'(opx[1]), 0);

        // Step-2 build at x=155: right move clamps to 156, then a second press is a no-op.
        sel = 2'd2;
        press(8'd35);
        capture(-1, np, nd, nb, fi, li, di, ei);
        check("redge_npix", np, 32);
        check("redge_ndone", nd, 1);
        verify_frame("redge", np, 1, 155, 10, 156, 10);
        check("redge_posx", int'(opx[2]), 156);
        press(8'd35);
        capture(-1, np, nd, nb, fi, li, di, ei);
        check("redge2_npix", np, 0);
        check("redge2_nbusy", nb, 2);
        check("redge2_posx", int'(opx[2]), 156);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
